// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared FSM state type and width helper for the FIFO write arbiter
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } arb_state_t;

    // Index width for N requesters; never returns less than 1 so ports stay legal.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational rotating-priority picker over the busy slots
module fifo_wr_arbiter_rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N = 2,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] i_busy,
    input  logic [W-1:0] i_ptr,
    output logic         o_any,
    output logic [W-1:0] o_winner
);

    // Search starts at the pointer and wraps; the first busy slot found wins.
    always_comb begin
        o_any    = 1'b0;
        o_winner = '0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (int'(i_ptr) + k) % N;
            if (!o_any && i_busy[idx]) begin
                o_any    = 1'b1;
                o_winner = W'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing one FIFO write port; FIFO_ARB_DROP_CNT_EN adds drop_cnt
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int N = 2,
    parameter  int B = 6,
    localparam int W = clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*B-1:0] req_data,
    output logic [N-1:0]   busy,
    output logic [N-1:0]   drop,
    input  logic           fifo_full,
    output logic           fifo_wr,
    output logic [B-1:0]   fifo_w_data,
    output logic [W-1:0]   grant_id
`ifdef FIFO_ARB_DROP_CNT_EN
    ,
    output logic [7:0]     drop_cnt
`endif
);

    arb_state_t   r_state;
    logic [W-1:0] r_ptr;
    logic [W-1:0] r_winner;
    logic [B-1:0] r_slot [N];
    logic [N-1:0] r_busy;
    logic [N-1:0] r_drop;
    logic         r_fifo_wr;
    logic [B-1:0] r_w_data;

    logic         w_any;
    logic [W-1:0] w_pick;
    logic [N-1:0] w_freed;
    logic [N-1:0] w_load;
    logic [N-1:0] w_reject;

    fifo_wr_arbiter_rr_pick #(
        .N (N),
        .W (W)
    ) u_rr_pick (
        .i_busy   (r_busy),
        .i_ptr    (r_ptr),
        .o_any    (w_any),
        .o_winner (w_pick)
    );

    // A slot being written this cycle counts as free, so a back-to-back tick is not lost.
    always_comb begin
        w_freed = '0;
        if (r_state == ST_WRITE) w_freed[r_winner] = 1'b1;
    end

    assign w_load   = req & (~r_busy | w_freed);
    assign w_reject = req & r_busy & ~w_freed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
            r_drop <= '0;
            for (int i = 0; i < N; i++) r_slot[i] <= '0;
        end else begin
            r_drop <= w_reject;
            for (int i = 0; i < N; i++) begin
                if (w_load[i]) begin
                    r_slot[i] <= req_data[i*B +: B];
                    r_busy[i] <= 1'b1;
                end else if (w_freed[i]) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_winner  <= '0;
            r_fifo_wr <= 1'b0;
            r_w_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any && !fifo_full) begin
                        r_state   <= ST_WRITE;
                        r_winner  <= w_pick;
                        r_fifo_wr <= 1'b1;
                        r_w_data  <= r_slot[w_pick];
                    end
                end
                ST_WRITE: begin
                    r_state   <= ST_IDLE;
                    r_fifo_wr <= 1'b0;
                    r_ptr     <= (r_winner == W'(N - 1)) ? '0 : r_winner + W'(1);
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef FIFO_ARB_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (|r_drop && r_drop_cnt != 8'hFF) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    assign busy        = r_busy;
    assign drop        = r_drop;
    assign fifo_wr     = r_fifo_wr;
    assign fifo_w_data = r_w_data;
    assign grant_id    = r_winner;

endmodule
